ex_core_alu_arb: RTL
====================

Name: ex_core_alu_arb

Overview:
- Shares a single 32-bit integer ALU datapath between NUM_REQ requesters.
- Requesters are, for example, the execute stage, the address-generation helper and a debug/test port.
- Round-robin arbitration over a valid/ready request interface.
- Two-stage registered pipeline (operand stage S1, result stage S2).
- Single broadcast response channel with backpressure, tagged with the requester ID.
- Sits inside ex_core between the issue logic and the writeback mux.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, $clog2(NUM_REQ), width of the requester ID (derived, not overridden).

Ports:
- Clk  in  1  core clock.
- Rst  in  1  synchronous reset, active-high.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_op1  in  NUM_REQ x 32  operand 1 per requester, packed.
- req_op2  in  NUM_REQ x 32  operand 2 per requester, packed.
- req_op  in  NUM_REQ x 3  ALU op per requester, packed.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  consumer accepts result.
- rsp_id  out  ID_W  requester index that owns the result.
- rsp_result  out  32  ALU result.
- rsp_zero  out  1  result == 0.

Behaviour:
- Reset:
  - Synchronous, active-high.
  - s1_valid=0, s2_valid=0, rr_ptr=0, rsp_valid=0, rsp_id=0, rsp_result=0, rsp_zero=0.
  - In-flight operations are dropped, with no response.
  - req_ready=0 while Rst=1.
- Op encoding:
  - 3'b000 ADD: op1+op2, mod 2^32.
  - 3'b001 SUB: op1-op2, mod 2^32.
  - All other codes: result=0.
  - zero = (result==0) for every op, including undefined ones (zero=1).
- Stall rule:
  - s2_adv = !s2_valid || rsp_ready.
  - s1_adv = !s1_valid || s2_adv.
- Grant:
  - When s1_adv=1, pick the first asserted req_valid searching rr_ptr, rr_ptr+1, ... wrapping at NUM_REQ-1 back to 0.
  - req_ready is combinational and one-hot on the winner; it is 0 when s1_adv=0 or no request is present.
  - Acceptance = req_valid[i] & req_ready[i].
- On acceptance:
  - S1 captures op1, op2, op and id; s1_valid=1.
  - rr_ptr <= winner+1 (mod NUM_REQ).
  - Without acceptance, rr_ptr holds.
- S1 -> S2:
  - When s2_adv, S2 captures the ALU result, zero flag and id computed from S1; s2_valid <= s1_valid.
  - When S1 advances with no new acceptance, s1_valid <= 0.
- Response:
  - rsp_* driven directly from S2 registers; rsp_valid = s2_valid.
  - While rsp_valid=1 and rsp_ready=0, rsp_id, rsp_result and rsp_zero hold stable.
- Latency and throughput:
  - Acceptance in cycle N gives rsp_valid in cycle N+2 when not stalled.
  - Throughput is 1 op/cycle.
  - At most 2 ops in flight.
- Simultaneous events:
  - Same-cycle rsp handshake plus new acceptance is legal; the pipeline slides with no bubble.
  - When S2 is full and not consumed and S1 is full, no grant is given.
- Fairness:
  - With all requesters continuously valid and no stall, grants rotate 0,1,...,NUM_REQ-1,0.
  - No requester waits more than NUM_REQ-1 grants.
- Requesters must hold valid and data stable until accepted. The arbiter does not latch unaccepted requests.

Optional Feature:
- Macro ALU_ARB_STATS_EN.
- When defined, adds outputs stat_grant_cnt (NUM_REQ x 16) and stat_stall_cnt (16):
  - Per-requester 16-bit saturating acceptance counters.
  - A saturating counter of cycles with any req_valid=1 but no acceptance.
  - Counters clear on Rst and saturate at 16'hFFFF.
- When undefined, these ports and counters do not exist; core behaviour is identical.

Decomposition:
- Package ex_core_alu_arb_pkg:
  - alu_op_t enum (ADD=3'b000, SUB=3'b001).
  - ALU_W=32.
  - Struct alu_req_t {op1, op2, op}.
  - Struct alu_rsp_t {id, result, zero}.
- Sub-module ex_core_alu_rr_pick: combinational round-robin picker.
  - Inputs: req vector, rr_ptr, enable.
  - Outputs: one-hot grant, winner index, any.
  - Reused by other ex_core shared resources.

Test Plan:
- Single-requester ops:
  - req 0 ADD op1=5 op2=3 accepted cycle N -> cycle N+2 rsp_valid=1, rsp_id=0, result=8, zero=0.
  - req 2 SUB 7-7 -> result=0, zero=1.
  - req 1 op=3'b111 -> result=0, zero=1.
- Wrap arithmetic:
  - ADD 32'hFFFFFFFF+1 -> result=0, zero=1.
  - SUB 0-1 -> 32'hFFFFFFFF, zero=0.
- Fairness: all 4 requesters continuously valid, rsp_ready=1 -> accept order 0,1,2,3,0,1 with one grant per cycle; rsp_id follows 2 cycles later.
- Backpressure: streaming requests, rsp_ready=0 for 3 cycles -> after 2 accepts req_ready=0, rsp_* hold stable, no loss or duplication after release.
- Priority rotation: rr_ptr=2, req_valid=4'b1011 -> grant req 3, then req 0, then req 1.
- Reset mid-flight: Rst=1 with S1 and S2 full -> next cycle rsp_valid=0, all rsp outputs 0, then the first grant goes to the lowest valid requester from rr_ptr=0.

Source files
------------

// File: rtl/ex_core_alu_arb_pkg.sv
// Shared types and the ALU helper for the shared integer ALU arbiter (ex_core_alu_arb).
package ex_core_alu_arb_pkg;

   localparam int ALU_W    = 32;
   localparam int OP_W     = 3;
   localparam int ID_MAX_W = 3;

   typedef enum logic [OP_W-1:0] {
      ADD = 3'b000,
      SUB = 3'b001
   } alu_op_t;

   typedef struct packed {
      logic [ALU_W-1:0] op1;
      logic [ALU_W-1:0] op2;
      logic [OP_W-1:0]  op;
   } alu_req_t;

   typedef struct packed {
      logic [ID_MAX_W-1:0] id;
      logic [ALU_W-1:0]    result;
      logic                zero;
   } alu_rsp_t;

   // Undefined opcodes produce zero so the zero flag reads 1 for them.
   function automatic logic [ALU_W-1:0] alu_exec(input logic [ALU_W-1:0] a,
                                                 input logic [ALU_W-1:0] b,
                                                 input logic [OP_W-1:0]  op);
      logic [ALU_W-1:0] res;
      case (op)
         ADD:     res = a + b;
         SUB:     res = a - b;
         default: res = {ALU_W{1'b0}};
      endcase
      return res;
   endfunction

endpackage

// File: rtl/ex_core_alu_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping.
// Shared by the ex_core resource arbiters.
module ex_core_alu_rr_pick #(
   parameter  int N = 4,
   localparam int W = $clog2(N)
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   input  logic         en,
   output logic [N-1:0] gnt,
   output logic [W-1:0] idx,
   output logic         any
);

   // Walk the request vector starting at ptr; the first hit wins and masks the rest.
   always_comb begin : pick
      int         pos;
      logic [W-1:0] pos_w;
      logic       hit;
      gnt   = {N{1'b0}};
      idx   = {W{1'b0}};
      any   = 1'b0;
      pos   = 0;
      pos_w = {W{1'b0}};
      hit   = 1'b0;
      for (int k = 0; k < N; k++) begin
         pos        = (int'(ptr) + k >= N) ? int'(ptr) + k - N : int'(ptr) + k;
         pos_w      = W'(pos);
         hit        = en & req[pos_w] & ~any;
         gnt[pos_w] = hit;
         idx        = hit ? pos_w : idx;
         any        = any | hit;
      end
   end

endmodule

// File: rtl/ex_core_alu_arb.sv
// Shared 32-bit ALU with round-robin arbitration, two-stage pipeline and tagged response.
// Optional build macro ALU_ARB_STATS_EN adds saturating grant/stall statistics counters.
module ex_core_alu_arb
   import ex_core_alu_arb_pkg::*;
#(
   parameter  int NUM_REQ = 4,
   localparam int ID_W    = $clog2(NUM_REQ)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_REQ-1:0]       req_valid,
   output logic [NUM_REQ-1:0]       req_ready,
   input  logic [NUM_REQ*ALU_W-1:0] req_op1,
   input  logic [NUM_REQ*ALU_W-1:0] req_op2,
   input  logic [NUM_REQ*OP_W-1:0]  req_op,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [ID_W-1:0]          rsp_id,
   output logic [ALU_W-1:0]         rsp_result,
   output logic                     rsp_zero
`ifdef ALU_ARB_STATS_EN
   ,
   output logic [NUM_REQ*16-1:0]    stat_grant_cnt,
   output logic [15:0]              stat_stall_cnt
`endif
);

   logic               s2_adv_s;
   logic               s1_adv_s;
   logic               pick_en_s;
   logic               any_s;
   logic [NUM_REQ-1:0] gnt_s;
   logic [ID_W-1:0]    win_s;
   logic [ID_W-1:0]    nxt_ptr_s;
   alu_req_t           win_req_s;
   alu_rsp_t           s1_rsp_s;
   logic [ALU_W-1:0]   s1_res_s;

   logic               s1_valid_r;
   logic               s2_valid_r;
   logic [ID_W-1:0]    rr_ptr_r;
   logic [ID_W-1:0]    s1_id_r;
   alu_req_t           s1_req_r;
   alu_rsp_t           s2_rsp_r;

   // A full S1 may only take a new op when S2 drains in the same cycle.
   assign s2_adv_s  = ~s2_valid_r | rsp_ready;
   assign s1_adv_s  = ~s1_valid_r | s2_adv_s;
   assign pick_en_s = s1_adv_s & ~rst;

   ex_core_alu_rr_pick #(.N(NUM_REQ)) u_pick (
      .req (req_valid),
      .ptr (rr_ptr_r),
      .en  (pick_en_s),
      .gnt (gnt_s),
      .idx (win_s),
      .any (any_s)
   );

   assign req_ready = gnt_s;
   assign nxt_ptr_s = (win_s == ID_W'(NUM_REQ - 1)) ? {ID_W{1'b0}} : win_s + ID_W'(1);

   // One-hot mux of the winning requester's operands.
   always_comb begin
      win_req_s = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         win_req_s.op1 = win_req_s.op1 | ({ALU_W{gnt_s[i]}} & req_op1[i*ALU_W +: ALU_W]);
         win_req_s.op2 = win_req_s.op2 | ({ALU_W{gnt_s[i]}} & req_op2[i*ALU_W +: ALU_W]);
         win_req_s.op  = win_req_s.op  | ({OP_W{gnt_s[i]}}  & req_op[i*OP_W +: OP_W]);
      end
   end

   assign s1_res_s        = alu_exec(s1_req_r.op1, s1_req_r.op2, s1_req_r.op);
   assign s1_rsp_s.id     = ID_MAX_W'(s1_id_r);
   assign s1_rsp_s.result = s1_res_s;
   assign s1_rsp_s.zero   = (s1_res_s == {ALU_W{1'b0}});

   // Pipeline registers and round-robin pointer; reset drops anything in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_r <= 1'b0;
         s2_valid_r <= 1'b0;
         rr_ptr_r   <= {ID_W{1'b0}};
         s1_id_r    <= {ID_W{1'b0}};
         s1_req_r   <= '0;
         s2_rsp_r   <= '0;
      end else begin
         if (s2_adv_s) begin
            s2_valid_r <= s1_valid_r;
            s2_rsp_r   <= s1_rsp_s;
         end
         if (s1_adv_s) begin
            s1_valid_r <= any_s;
         end
         if (any_s) begin
            s1_req_r <= win_req_s;
            s1_id_r  <= win_s;
            rr_ptr_r <= nxt_ptr_s;
         end
      end
   end

   assign rsp_valid  = s2_valid_r;
   assign rsp_id     = s2_rsp_r.id[ID_W-1:0];
   assign rsp_result = s2_rsp_r.result;
   assign rsp_zero   = s2_rsp_r.zero;

`ifdef ALU_ARB_STATS_EN
   logic [NUM_REQ*16-1:0] grant_cnt_r;
   logic [15:0]           stall_cnt_r;

   // Saturating acceptance counters per requester plus a starved-cycle counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         grant_cnt_r <= '0;
         stall_cnt_r <= 16'h0000;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_s[i] && req_valid[i] && (grant_cnt_r[i*16 +: 16] != 16'hFFFF)) begin
               grant_cnt_r[i*16 +: 16] <= grant_cnt_r[i*16 +: 16] + 16'h0001;
            end
         end
         if ((|req_valid) && !any_s && (stall_cnt_r != 16'hFFFF)) begin
            stall_cnt_r <= stall_cnt_r + 16'h0001;
         end
      end
   end

   assign stat_grant_cnt = grant_cnt_r;
   assign stat_stall_cnt = stall_cnt_r;
`endif

endmodule
